// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one 11-bit carry-propagate adder among NUM_REQ requesters,
// with a single registered result stage. Define SHARED_ADDER_FIXED_PRIO_EN for fixed priority.

module carry_prop_adder #(
    parameter int W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    // Carry-out is intentionally dropped: sums wrap modulo 2**W.
    assign sum = a + b;
endmodule

module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*11-1:0] req_a,
    input  logic [NUM_REQ*11-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [10:0]          res_sum,
    output logic [ID_W-1:0]      res_id,
    output logic                 busy
);
    localparam int W = 11;

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // ready never depends on anything registered downstream of this block except res_ready.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id, gid_hi, gid_lo;
    logic            found_hi, found_lo, grant_found;
    logic            can_accept, transfer;
    logic [W-1:0]    a_sel, b_sel, sum;

    // Two passes give a wrapping scan: lowest valid at/above rr_ptr first, else lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        gid_hi   = '0;
        gid_lo   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                found_hi = 1'b1;
                gid_hi   = ID_W'(i);
            end
            if (req_valid[i]) begin
                found_lo = 1'b1;
                gid_lo   = ID_W'(i);
            end
        end
        grant_found = found_hi | found_lo;
        grant_id    = found_hi ? gid_hi : gid_lo;
    end

    assign can_accept = (state == EMPTY) || res_ready;
    assign transfer   = rst_n && grant_found && can_accept;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                req_ready[i] = transfer;
                a_sel        = req_a[i*W +: W];
                b_sel        = req_b[i*W +: W];
            end
        end
    end

    carry_prop_adder #(.W(W)) u_adder (
        .a   (a_sel),
        .b   (b_sel),
        .sum (sum)
    );

`ifdef SHARED_ADDER_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end
`endif

    // Output stage: a transfer always (re)fills the register, so drain+fill keeps it FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            res_sum <= '0;
            res_id  <= '0;
        end else if (transfer) begin
            state   <= FULL;
            res_sum <= sum;
            res_id  <= grant_id;
        end else if ((state == FULL) && res_ready) begin
            state   <= EMPTY;
        end
    end

    assign res_valid = (state == FULL);
    assign busy      = res_valid;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed vector table, corner sequences,
// and randomized traffic against a scan-order reference model with a result queue.

module tb_adder_share_arbiter;
    localparam int NREQ = 4;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*11-1:0]   req_a;
    logic [NREQ*11-1:0]   req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [10:0]          res_sum;
    logic [1:0]           res_id;
    logic                 busy;

    int n_checks = 0;
    int n_errors = 0;

    adder_share_arbiter #(.NUM_REQ(NREQ), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pointer as an integer, pending results in queues.
`ifdef SHARED_ADDER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    int          m_ptr = 0;
    logic [10:0] exp_q[$];
    int          id_q[$];
    logic [10:0] last_sum = '0;
    int          last_id = 0;
    logic [NREQ-1:0] hs = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        exp_q.delete();
        id_q.delete();
        last_sum = '0;
        last_id = 0;
    endtask

    function automatic int m_grant();
        int start;
        start = FIXED ? 0 : m_ptr;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (start + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_slot(input int idx, input logic [10:0] a, input logic [10:0] b);
        req_a[idx*11 +: 11] = a;
        req_b[idx*11 +: 11] = b;
    endtask

    // One clock: check ready before the edge, advance model, check outputs on the falling edge.
    task automatic cycle();
        int              g;
        bit              full;
        logic [NREQ-1:0] exp_ready;
        logic [10:0]     s;
        #1;
        g = m_grant();
        full = (exp_q.size() > 0);
        exp_ready = '0;
        if (g >= 0 && (!full || res_ready)) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        s = '0;
        if (g >= 0) s = 11'((int'(req_a[g*11 +: 11]) + int'(req_b[g*11 +: 11])) % 2048);
        hs = exp_ready;
        @(posedge clk);
        if (exp_ready != '0) begin
            if (full) begin
                void'(exp_q.pop_front());
                void'(id_q.pop_front());
            end
            exp_q.push_back(s);
            id_q.push_back(g);
            last_sum = s;
            last_id = g;
            if (!FIXED) m_ptr = (g + 1) % NREQ;
        end else if (full && res_ready) begin
            void'(exp_q.pop_front());
            void'(id_q.pop_front());
        end
        @(negedge clk);
        check("res_valid", 32'(res_valid), 32'(exp_q.size() > 0));
        check("busy", 32'(busy), 32'(exp_q.size() > 0));
        check("res_sum", 32'(res_sum), 32'(last_sum));
        check("res_id", 32'(res_id), 32'(last_id));
    endtask

    typedef struct {
        int          idx;
        logic [10:0] a;
        logic [10:0] b;
        logic [10:0] sum;
    } vec_t;

    vec_t vecs[6];
    int   rr_exp[5];
    logic [10:0] snap_sum;
    logic [1:0]  snap_id;

    initial begin
        vecs[0] = '{0, 11'h123, 11'h0FF, 11'h222};
        vecs[1] = '{1, 11'h7FF, 11'h001, 11'h000};
        vecs[2] = '{2, 11'h400, 11'h400, 11'h000};
        vecs[3] = '{3, 11'h3FF, 11'h3FF, 11'h7FE};
        vecs[4] = '{0, 11'h555, 11'h2AA, 11'h7FF};
        vecs[5] = '{2, 11'h001, 11'h7FE, 11'h7FF};
        for (int i = 0; i < 5; i++) rr_exp[i] = FIXED ? 0 : (i % NREQ);

        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_valid = '1;
        res_ready = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Single adds through the vector table, each followed by a drain cycle.
        foreach (vecs[v]) begin
            req_valid = '0;
            req_valid[vecs[v].idx] = 1'b1;
            set_slot(vecs[v].idx, vecs[v].a, vecs[v].b);
            res_ready = 1'b1;
            cycle();
            check("vec_valid", 32'(res_valid), 32'd1);
            check("vec_sum", 32'(res_sum), 32'(vecs[v].sum));
            check("vec_id", 32'(res_id), 32'(vecs[v].idx));
            req_valid = '0;
            cycle();
            check("vec_drain", 32'(res_valid), 32'd0);
        end

        // Reset while FULL discards the pending result immediately.
        req_valid = 4'b0001;
        set_slot(0, 11'h155, 11'h000);
        res_ready = 1'b0;
        cycle();
        check("pre_rst_sum", 32'(res_sum), 32'h155);
        res_ready = 1'b1;
        req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_res_sum", 32'(res_sum), 32'd0);
        check("arst_res_id", 32'(res_id), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Round-robin with all requesters valid and downstream always ready.
        for (int i = 0; i < NREQ; i++) set_slot(i, 11'(16 * i + 1), 11'(i));
        req_valid = '1;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_id", 32'(res_id), 32'(rr_exp[i]));
            check("rr_valid", 32'(res_valid), 32'd1);
        end

        // Backpressure: outputs frozen and no grants while res_ready is low.
        snap_sum = res_sum;
        snap_id = res_id;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_sum", 32'(res_sum), 32'(snap_sum));
            check("bp_id", 32'(res_id), 32'(snap_id));
            check("bp_valid", 32'(res_valid), 32'd1);
        end
        res_ready = 1'b1;
        cycle();
        check("bp_release_id", 32'(res_id), FIXED ? 32'd0 : 32'd1);

        // Pointer skip: pointer sits at 2, only 1 and 3 requesting.
        req_valid = 4'b1010;
        cycle();
        check("skip_first", 32'(res_id), FIXED ? 32'd1 : 32'd3);
        cycle();
        check("skip_second", 32'(res_id), 32'd1);
        req_valid = 4'b1100;
        cycle();
        check("skip_ptr", 32'(res_id), 32'd2);
        req_valid = '0;
        cycle();

        // Randomized traffic; requesters hold valid and operands until their handshake.
        hs = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_slot(i, 11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 11-bit carry_prop_adder instance among NUM_REQ requesters in the approximate BF16 multiplier. Typical requesters are the exponent add/bias path and the mantissa final-add paths.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- Results come from a single registered output stage, tagged with the requester index.
- The block removes duplicated carry-propagate adders at the cost of one cycle of latency.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of res_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*11  operand A; slot i is bits [11*i+10 : 11*i].
- req_b  in  NUM_REQ*11  operand B; same slot layout as req_a.
- res_valid  out  1  result register holds a valid sum.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  11  registered sum of the granted operands.
- res_id  out  ID_W  index of the requester that produced res_sum.
- busy  out  1  equals res_valid; provided for the upstream stall logic.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: res_valid=0, res_sum=0, res_id=0, busy=0, rr_ptr=0.
  - Any result pending when reset asserts is discarded.
  - req_ready is all-zero while rst_n=0.
- State machine (output stage): EMPTY (res_valid=0) and FULL (res_valid=1).
- can_accept = (state==EMPTY) or res_ready.
- Arbitration (combinational, evaluated every cycle):
  - Scan req_valid starting at index rr_ptr, ascending, wrapping NUM_REQ-1 -> 0.
  - The first valid index found is g.
  - req_ready[g] = can_accept. All other req_ready bits = 0.
  - If no req_valid bit is set, req_ready = 0.
- Transfer: a transfer occurs when req_valid[g] && req_ready[g].
  - On the next edge: res_sum <= (a_g + b_g) mod 2^11, computed through the carry_prop_adder instance (carry-out dropped).
  - On the same edge: res_id <= g, state <= FULL, rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1.
- Drain: in FULL with res_ready=1 and no transfer -> state <= EMPTY. res_sum and res_id hold their last values.
- Simultaneous drain and transfer in FULL: the new result replaces the old in the same edge and state stays FULL. This sustains one result per cycle.
- Backpressure: in FULL with res_ready=0:
  - res_sum, res_id and res_valid hold.
  - req_ready = 0 and rr_ptr holds, so the grant is stable while requesters keep valid asserted.
- Latency: exactly 1 cycle from the handshake edge to res_valid=1. Throughput: 1 add per cycle when res_ready is held high.
- Requester rule: keep req_valid, req_a and req_b stable until handshake. Operands are sampled only at the handshake edge.
  - If a requester drops req_valid before handshake, the grant is re-evaluated in that cycle.
  - The block does not flag such a drop as an error.
- req_ready[i] is combinationally dependent on req_valid and res_ready. The upstream must not make req_valid depend on req_ready.

Optional Feature:
- Macro: SHARED_ADDER_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest asserted index always wins. rr_ptr is tied to 0 and never updated. Starvation of higher indices is permitted.
- Undefined (default): round-robin as described in Behaviour.
- All other behaviour and all ports are identical in both builds.

Test Plan:
- Reset: assert rst_n=0 while FULL with res_sum=0x155 -> immediately res_valid=0, res_sum=0, res_id=0, req_ready=0. After release, first grant goes to index 0.
- Single add: req_valid=4'b0001, a0=0x123, b0=0x0FF, res_ready=1 -> next cycle res_valid=1, res_sum=0x222, res_id=0. The cycle after that, res_valid=0.
- Wrap: a=0x7FF, b=0x001 -> res_sum=0x000. Then a=0x400, b=0x400 -> res_sum=0x000. Then a=0x3FF, b=0x3FF -> res_sum=0x7FE.
- Round-robin: all four valid continuously, res_ready=1 -> res_id sequence 0,1,2,3,0 on consecutive cycles, one result per cycle. With SHARED_ADDER_FIXED_PRIO_EN defined -> 0,0,0,0,0.
- Backpressure: FULL with res_ready=0 for 3 cycles -> res_sum, res_id and res_valid stable and req_ready=0. On the cycle res_ready=1, the next requester is accepted and the new result appears on the following edge.
- Pointer skip: rr_ptr=2 with only req1 and req3 valid -> grant 3 first, then 1; rr_ptr ends at 2.
